rx_comandos_serial: RTL
=======================

Name: rx_comandos_serial

Overview:
- UART receiver with command decoder for the RX line of the water-level controller; the receive-side counterpart of the controller's serial transmitter.
- Deserialises 8N1 frames from the operator terminal, validates start and stop bits, and publishes each received byte.
- Decodes ASCII commands into valve open/close pulses and a manual/automatic mode level.
- Its outputs drive the valve control logic; the mode level is the source of db_manual.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); minimum legal value 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the start-bit falling edge to the start-bit mid-sample.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- RX  in  1  serial line; idles high; asynchronous to clock
- dado  out  8  last byte received with a valid stop bit
- dado_valido  out  1  1-cycle pulse when dado updates
- erro_quadro  out  1  1-cycle pulse on a stop-bit error
- cmd_abre  out  1  1-cycle pulse: open valve
- cmd_fecha  out  1  1-cycle pulse: close valve
- cmd_desconhecido  out  1  1-cycle pulse: valid byte that is not a command
- modo_manual  out  1  level: 1 = manual, 0 = automatic
- db_estado  out  4  current FSM state code

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to OCIOSO; dado=0x00; modo_manual=0; all pulses 0; counters 0; synchroniser flops preset to 1.
- RX input: passes through a 2-flop synchroniser to give rx_s; all FSM decisions use rx_s only.
- Counters:
  - tick counter counts 0..CLKS_PER_BIT-1;
  - bit counter counts 0..7;
  - both clear on every state entry.
- FSM states (db_estado code in brackets):
  - OCIOSO [0]: on rx_s=0, go to INICIO.
  - INICIO [1]: at tick=HALF_BIT-1, sample rx_s. If 0, go to DADOS. If 1, treat as a glitch and return to OCIOSO with no output.
  - DADOS [2]: every CLKS_PER_BIT ticks, sample rx_s into a shift register, LSB first. After the 8th sample, go to PARADA.
  - PARADA [3]: after CLKS_PER_BIT ticks, sample rx_s. If 1, go to FINAL. If 0, go to ERRO.
  - FINAL [4]: lasts one cycle.
    - dado <= shift register and dado_valido=1.
    - Decode the byte in the same cycle (see command table below).
    - Then return to OCIOSO.
  - ERRO [5]: erro_quadro=1 in the entry cycle only.
    - dado is unchanged and no command is decoded.
    - Stay in ERRO until rx_s=1 for CLKS_PER_BIT consecutive cycles, then go to OCIOSO. This covers a break condition.
- Command table (applied only in FINAL):
  - 0x41 or 0x61 ('A'/'a'): cmd_abre=1.
  - 0x46 or 0x66 ('F'/'f'): cmd_fecha=1.
  - 0x4D or 0x6D ('M'/'m'): modo_manual <= 1.
  - 0x55 or 0x75 ('U'/'u'): modo_manual <= 0.
  - Any other byte: cmd_desconhecido=1.
  - cmd_abre and cmd_fecha are emitted regardless of modo_manual; gating them is the consumer's job.
- Latency: dado_valido and the command pulses assert exactly 1 cycle after the stop-bit sample, i.e. about 9.5 bit times plus 3 cycles after the start edge at RX.
- Back-to-back frames: a start bit immediately after a stop bit is accepted, because FINAL returns to OCIOSO within one cycle.
- Unused encodings 6..15: treated as illegal and go to OCIOSO on the next clock.
- Reset during a frame: the partial byte is discarded and modo_manual returns to 0.

Decomposition:
- Shared package: state codes (OCIOSO..ERRO) and command byte constants (CMD_ABRE_MAI/MIN, CMD_FECHA_*, CMD_MANUAL_*, CMD_AUTO_*).
- One natural sub-module: rx_serial_8N1, covering synchroniser, FSM, counters and shift register, with outputs dado/dado_valido/erro_quadro.
- The command decoder stays in the parent as a registered combinational decode plus the modo_manual flop.

Test Plan (CLKS_PER_BIT=16):
- Frame 0x61 ('a') at 16 cycles/bit → dado=0x61, one dado_valido pulse, one cmd_abre pulse, no other pulses, modo_manual stays 0.
- 'M' then 'f' back-to-back with no idle gap → modo_manual=1 after the first frame; then dado=0x66, cmd_fecha pulse, modo_manual still 1.
- 'U' after 'M' → modo_manual returns to 0; 0x5A → cmd_desconhecido pulse only.
- 4-cycle low glitch on RX → FSM returns to OCIOSO from INICIO; no dado_valido; dado unchanged.
- Frame 0x41 with stop bit forced low, RX held low 40 cycles, then high → erro_quadro pulses once; dado and modo_manual unchanged; FSM waits in ERRO until 16 high cycles, then a following 'a' frame decodes correctly.
- reset asserted low mid-DADOS after 'M' was accepted → immediate OCIOSO, dado=0x00, modo_manual=0, db_estado=0.

Source files
------------

// File: rtl/rx_comandos_serial_pkg.sv
// Shared definitions for the RX command path: receiver state codes and
// the ASCII command bytes understood from the operator terminal.
package rx_comandos_serial_pkg;

  typedef enum logic [3:0] {
    OCIOSO = 4'd0,
    INICIO = 4'd1,
    DADOS  = 4'd2,
    PARADA = 4'd3,
    FINAL  = 4'd4,
    ERRO   = 4'd5
  } estado_t;

  localparam logic [7:0] CMD_ABRE_MAI   = 8'h41; // 'A'
  localparam logic [7:0] CMD_ABRE_MIN   = 8'h61; // 'a'
  localparam logic [7:0] CMD_FECHA_MAI  = 8'h46; // 'F'
  localparam logic [7:0] CMD_FECHA_MIN  = 8'h66; // 'f'
  localparam logic [7:0] CMD_MANUAL_MAI = 8'h4D; // 'M'
  localparam logic [7:0] CMD_MANUAL_MIN = 8'h6D; // 'm'
  localparam logic [7:0] CMD_AUTO_MAI   = 8'h55; // 'U'
  localparam logic [7:0] CMD_AUTO_MIN   = 8'h75; // 'u'

endpackage

// File: rtl/rx_serial_8N1.sv
// 8N1 UART receiver: input synchroniser, framing FSM, tick/bit counters and
// LSB-first shift register. Publishes each byte that ends in a valid stop bit.
module rx_serial_8N1
  import rx_comandos_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       dado_valido,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TICK_W   = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(HALF_BIT - 1);

  estado_t           estado, estado_prox;
  logic              rx_m, rx_s;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bits;
  logic [7:0]        shift;
  logic              fim_bit, amostra;

  // Synchroniser presets to the idle-high line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign fim_bit = (tick == LAST_TICK);

  always_comb begin
    estado_prox = estado;
    amostra     = 1'b0;
    case (estado)
      OCIOSO: if (!rx_s) estado_prox = INICIO;
      INICIO: if (tick == HALF_TICK) estado_prox = rx_s ? OCIOSO : DADOS;
      DADOS: begin
        if (fim_bit) begin
          amostra = 1'b1;
          if (bits == 3'd7) estado_prox = PARADA;
        end
      end
      PARADA: if (fim_bit) estado_prox = rx_s ? FINAL : ERRO;
      FINAL:  estado_prox = OCIOSO;
      // In ERRO the tick counter measures consecutive idle-high cycles.
      ERRO:   if (rx_s && fim_bit) estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      tick        <= '0;
      bits        <= '0;
      shift       <= '0;
      dado        <= '0;
      dado_valido <= 1'b0;
      erro_quadro <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (estado_prox != estado) begin
        tick <= '0;
        bits <= '0;
      end else if (estado == ERRO && !rx_s) begin
        tick <= '0;
      end else begin
        tick <= fim_bit ? '0 : tick + 1'b1;
        if (amostra) bits <= bits + 3'd1;
      end
      if (amostra) shift <= {rx_s, shift[7:1]};
      // Byte and strobes are registered so they line up with FINAL / ERRO entry.
      dado_valido <= (estado == PARADA) && (estado_prox == FINAL);
      erro_quadro <= (estado == PARADA) && (estado_prox == ERRO);
      if ((estado == PARADA) && (estado_prox == FINAL)) dado <= shift;
    end
  end

  assign db_estado = estado;

endmodule

// File: rtl/rx_comandos_serial.sv
// Operator-terminal RX path: UART receiver plus ASCII command decoder that
// drives valve open/close pulses and the manual/automatic mode level.
module rx_comandos_serial
  import rx_comandos_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] dado,
  output logic       dado_valido,
  output logic       erro_quadro,
  output logic       cmd_abre,
  output logic       cmd_fecha,
  output logic       cmd_desconhecido,
  output logic       modo_manual,
  output logic [3:0] db_estado
);

  logic eh_manual, eh_auto;

  rx_serial_8N1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (RX),
    .dado        (dado),
    .dado_valido (dado_valido),
    .erro_quadro (erro_quadro),
    .db_estado   (db_estado)
  );

  // Decode of the registered byte, qualified by the FINAL-cycle strobe.
  always_comb begin
    cmd_abre         = 1'b0;
    cmd_fecha        = 1'b0;
    cmd_desconhecido = 1'b0;
    eh_manual        = 1'b0;
    eh_auto          = 1'b0;
    if (dado_valido) begin
      case (dado)
        CMD_ABRE_MAI,   CMD_ABRE_MIN:   cmd_abre  = 1'b1;
        CMD_FECHA_MAI,  CMD_FECHA_MIN:  cmd_fecha = 1'b1;
        CMD_MANUAL_MAI, CMD_MANUAL_MIN: eh_manual = 1'b1;
        CMD_AUTO_MAI,   CMD_AUTO_MIN:   eh_auto   = 1'b1;
        default:                        cmd_desconhecido = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      modo_manual <= 1'b0;
    end else if (eh_manual) begin
      modo_manual <= 1'b1;
    end else if (eh_auto) begin
      modo_manual <= 1'b0;
    end
  end

endmodule
